morse_receiver: RTL



---
 rtl/morse_receiver.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/morse_receiver.sv
// Morse keying front end: synchronises and debounces a raw key, classifies
// presses as dot/dash and emits one character code (or a space) per gap.
module morse_receiver #(
    parameter int TICK_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int DOT_MAX_TICKS  = 200,
    parameter int CHAR_GAP_TICKS = 400,
    parameter int WORD_GAP_TICKS = 1000
) (
    input  logic       clk_100Mhz,
    input  logic       reset_n,
    input  logic       key_in,
    output logic       data_valid,
    output logic [2:0] char_index,
    output logic [5:0] char_data,
    output logic       key_level
);

    localparam int          TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          DB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [15:0] DUR_MAX = 16'hFFFF;

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_WORD} state_t;

    logic              key_sync_p0, key_sync_p1;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [DB_W-1:0]   stable_cnt;
    logic              toggle, press_evt, release_evt;
    logic [15:0]       dur, dur_inc;
    logic              char_hit, word_hit;
    logic              sym;
    logic [5:0]        acc;
    logic [2:0]        cnt;
    logic              ovf;
    state_t            state, state_nxt;
    logic              append, set_ovf, clear_acc, emit_char, emit_space;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == DUR_MAX) ? v : v + 16'd1;
    endfunction

    function automatic logic classify(input logic [15:0] ticks_held);
        return ticks_held > 16'(DOT_MAX_TICKS);
    endfunction

    // Input synchroniser
    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            key_sync_p0 <= 1'b0;
            key_sync_p1 <= 1'b0;
        end else begin
            key_sync_p0 <= key_in;
            key_sync_p1 <= key_sync_p0;
        end
    end

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) tick_cnt <= '0;
        else          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
    end

    // Debounce: key events are the ticks on which key_level changes
    assign toggle      = tick && (key_sync_p1 != key_level) &&
                         (stable_cnt == DB_W'(DEBOUNCE_TICKS - 1));
    assign press_evt   = toggle && !key_level;
    assign release_evt = toggle && key_level;

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt <= '0;
            key_level  <= 1'b0;
        end else if (tick) begin
            if (key_sync_p1 == key_level) begin
                stable_cnt <= '0;
            end else if (toggle) begin
                stable_cnt <= '0;
                key_level  <= ~key_level;
            end else begin
                stable_cnt <= stable_cnt + DB_W'(1);
            end
        end
    end

    // The event tick itself counts toward the interval it closes
    assign dur_inc  = sat_inc(dur);
    assign sym      = classify(dur_inc);
    assign char_hit = tick && (dur == 16'(CHAR_GAP_TICKS - 1));
    assign word_hit = tick && (dur == 16'(WORD_GAP_TICKS - 1));

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n)                      dur <= '0;
        else if (press_evt || release_evt) dur <= '0;
        else if (tick)                     dur <= dur_inc;
    end

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // A press always takes priority over a gap threshold on the same tick
    always_comb begin
        state_nxt  = state;
        append     = 1'b0;
        set_ovf    = 1'b0;
        clear_acc  = 1'b0;
        emit_char  = 1'b0;
        emit_space = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_evt) state_nxt = S_PRESS;
            end
            S_PRESS: begin
                if (release_evt) begin
                    if (cnt < 3'd5) append  = 1'b1;
                    else            set_ovf = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (press_evt) begin
                    state_nxt = S_PRESS;
                end else if (char_hit) begin
                    emit_char = !ovf;
                    clear_acc = 1'b1;
                    state_nxt = S_WORD;
                end
            end
            S_WORD: begin
                if (press_evt) begin
                    state_nxt = S_PRESS;
                end else if (word_hit) begin
                    emit_space = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            data_valid <= 1'b0;
            char_index <= '0;
            char_data  <= '0;
        end else begin
            data_valid <= emit_char || emit_space;
            if (clear_acc) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (append) begin
                acc <= {acc[4:0], sym};
                cnt <= cnt + 3'd1;
            end else if (set_ovf) begin
                ovf <= 1'b1;
            end
            if (emit_char) begin
                char_index <= cnt - 3'd1;
                char_data  <= acc;
            end else if (emit_space) begin
                char_index <= 3'd5;
                char_data  <= '0;
            end
        end
    end

endmodule
